// File: rtl/uart_tx_feeder.sv
// Byte FIFO and launch sequencer feeding the UART transmitter (TX clock domain).
// Define UART_TXF_OVERFLOW_FLAG_EN to add the sticky OVERFLOW flag and OVF_CLR input.
module uart_tx_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_W       = 3,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR_EN,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  TX_BUSY,
`ifdef UART_TXF_OVERFLOW_FLAG_EN
    input  logic                  OVF_CLR,
    output logic                  OVERFLOW,
`endif
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_DATA_VALID,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [ADDR_W:0]       FIFO_LEVEL
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                state;
    logic [CW-1:0]         wait_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]       wr_ptr;
    logic [ADDR_W:0]       rd_ptr;
    logic                  push;
    logic                  pop;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign EMPTY      = (wr_ptr == rd_ptr);
    assign FULL       = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign FIFO_LEVEL = wr_ptr - rd_ptr;
    assign push       = WR_EN && !FULL;
    assign pop        = (state == IDLE) && !EMPTY && !TX_BUSY;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // A launch that never sees busy is treated as consumed, not retried.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            TX_P_DATA     <= '0;
            TX_DATA_VALID <= 1'b0;
        end else begin
            TX_DATA_VALID <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        TX_P_DATA     <= mem[rd_ptr[ADDR_W-1:0]];
                        TX_DATA_VALID <= 1'b1;
                        state         <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (TX_BUSY) begin
                        state <= WAIT_DONE;
                    end else if (wait_cnt == LAST) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!TX_BUSY) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_TXF_OVERFLOW_FLAG_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVERFLOW <= 1'b0;
        end else if (WR_EN && FULL) begin
            OVERFLOW <= 1'b1;
        end else if (OVF_CLR) begin
            OVERFLOW <= 1'b0;
        end
    end
`endif

endmodule
